// File: rtl/trap_ctrl.sv
// Machine-mode trap responder. Takes exception requests, the external
// interrupt and MRET, and owns the trap CSRs: mstatus, mie, mtvec, mscratch,
// mepc, mcause, mtval and mip. A taken trap updates the CSRs and redirects
// fetch to the trap vector. MRET redirects fetch to mepc.
//
// Optional feature: define COTM32_MTVEC_VECTORED_EN to enable vectored mtvec
// (MODE WARL {0,1}; MODE=1 sends the interrupt to BASE+0x2C).
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_inst_valid, i_pc        retiring instruction and its PC
//   i_trap_req/_cause/_tval   synchronous exception request from trap dispatch
//   i_mret                    MRET retiring
//   i_irq_ext                 asynchronous machine external interrupt line
//   i_csr_addr/_we/_wdata     Zicsr access; write data is the final RMW value
//   o_csr_rdata, o_csr_hit    combinational CSR read and address-hit flag
//   o_redirect, o_redirect_pc registered fetch redirect and its target
//   o_busy                    registered; high while the FSM is not idle
module trap_ctrl #(
  parameter logic [31:0] RESET_MTVEC     = 32'h0000_0000,
  parameter int unsigned IRQ_SYNC_STAGES = 2,
  parameter type         trap_cause_t    = logic [4:0]
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_inst_valid,
  input  logic [31:0] i_pc,
  input  logic        i_trap_req,
  input  trap_cause_t i_trap_cause,
  input  logic [31:0] i_trap_tval,
  input  logic        i_mret,
  input  logic        i_irq_ext,
  input  logic [11:0] i_csr_addr,
  input  logic        i_csr_we,
  input  logic [31:0] i_csr_wdata,
  output logic [31:0] o_csr_rdata,
  output logic        o_csr_hit,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_busy
);

  localparam int unsigned XLEN = 32;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [XLEN-1:0] MCAUSE_MEI   = 32'h8000_000B;
  localparam logic [XLEN-1:0] IRQ_VEC_OFS  = 32'h0000_002C;
  localparam logic [XLEN-1:0] ALIGN4_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTER = 2'd1,
    ST_EXIT  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   mie_q, mie_d;
  logic                   mpie_q, mpie_d;
  logic                   meie_q, meie_d;
  logic [XLEN-3:0]        base_q, base_d;
  logic [XLEN-1:0]        mscratch_q, mscratch_d;
  logic [XLEN-1:0]        mepc_q, mepc_d;
  logic [XLEN-1:0]        mcause_q, mcause_d;
  logic [XLEN-1:0]        mtval_q, mtval_d;
  logic                   redirect_q, redirect_d;
  logic [XLEN-1:0]        redirect_pc_q, redirect_pc_d;
  logic                   busy_q, busy_d;
  logic [IRQ_SYNC_STAGES-1:0] sync_q;

  logic                   irq_sync;
  logic                   irq_pend;
  logic                   idle;
  logic                   take_exc, take_irq, take_mret, do_csr_wr;
  logic [XLEN-1:0]        mtvec_rd;
  logic [XLEN-1:0]        irq_target;

  // External interrupt synchroniser
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= i_irq_ext;
      for (int unsigned i = 1; i < IRQ_SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign irq_sync = sync_q[IRQ_SYNC_STAGES-1];
  assign irq_pend = mie_q & meie_q & irq_sync;

  // Event arbitration: exception > interrupt > mret > CSR write
  assign idle      = (state_q == ST_IDLE);
  assign take_exc  = idle & i_inst_valid & i_trap_req;
  assign take_irq  = idle & i_inst_valid & irq_pend & ~i_trap_req;
  assign take_mret = idle & i_inst_valid & i_mret & ~i_trap_req & ~irq_pend;
  assign do_csr_wr = idle & i_inst_valid & i_csr_we & ~i_trap_req & ~irq_pend & ~i_mret;

`ifdef COTM32_MTVEC_VECTORED_EN
  logic mode_q, mode_d;

  // Only MODE values 0 and 1 are legal; anything else keeps the old MODE
  always_comb begin
    mode_d = mode_q;
    if (do_csr_wr && (i_csr_addr == ADDR_MTVEC) && (i_csr_wdata[1] == 1'b0)) begin
      mode_d = i_csr_wdata[0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end

  assign mtvec_rd   = {base_q, 1'b0, mode_q};
  assign irq_target = mode_q ? ({base_q, 2'b00} + IRQ_VEC_OFS) : {base_q, 2'b00};
`else
  assign mtvec_rd   = {base_q, 2'b00};
  assign irq_target = {base_q, 2'b00};
`endif

  // Next-state, CSR update and redirect generation
  always_comb begin
    state_d       = state_q;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    meie_d        = meie_q;
    base_d        = base_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    busy_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (take_exc || take_irq) begin
          mepc_d        = i_pc & ALIGN4_MASK;
          mcause_d      = take_exc ? {1'b0, (XLEN-1)'(i_trap_cause)} : MCAUSE_MEI;
          mtval_d       = take_exc ? i_trap_tval : '0;
          mpie_d        = mie_q;
          mie_d         = 1'b0;
          state_d       = ST_ENTER;
          redirect_d    = 1'b1;
          busy_d        = 1'b1;
          redirect_pc_d = take_irq ? irq_target : {base_q, 2'b00};
        end else if (take_mret) begin
          mie_d         = mpie_q;
          mpie_d        = 1'b1;
          state_d       = ST_EXIT;
          redirect_d    = 1'b1;
          busy_d        = 1'b1;
          redirect_pc_d = mepc_q;
        end else if (do_csr_wr) begin
          case (i_csr_addr)
            ADDR_MSTATUS: begin
              mie_d  = i_csr_wdata[3];
              mpie_d = i_csr_wdata[7];
            end
            ADDR_MIE:      meie_d     = i_csr_wdata[11];
            ADDR_MTVEC:    base_d     = i_csr_wdata[XLEN-1:2];
            ADDR_MSCRATCH: mscratch_d = i_csr_wdata;
            ADDR_MEPC:     mepc_d     = i_csr_wdata & ALIGN4_MASK;
            ADDR_MCAUSE:   mcause_d   = i_csr_wdata;
            ADDR_MTVAL:    mtval_d    = i_csr_wdata;
            default: ;
          endcase
        end
      end
      ST_ENTER: state_d = ST_IDLE;
      ST_EXIT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      meie_q        <= 1'b0;
      base_q        <= RESET_MTVEC[XLEN-1:2];
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      meie_q        <= meie_d;
      base_q        <= base_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      busy_q        <= busy_d;
    end
  end

  // Combinational CSR read port
  always_comb begin
    o_csr_rdata = '0;
    o_csr_hit   = 1'b1;
    case (i_csr_addr)
      ADDR_MSTATUS:  o_csr_rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      ADDR_MIE:      o_csr_rdata = {20'b0, meie_q, 11'b0};
      ADDR_MTVEC:    o_csr_rdata = mtvec_rd;
      ADDR_MSCRATCH: o_csr_rdata = mscratch_q;
      ADDR_MEPC:     o_csr_rdata = mepc_q;
      ADDR_MCAUSE:   o_csr_rdata = mcause_q;
      ADDR_MTVAL:    o_csr_rdata = mtval_q;
      ADDR_MIP:      o_csr_rdata = {20'b0, irq_sync, 11'b0};
      default:       o_csr_hit   = 1'b0;
    endcase
  end

  assign o_redirect    = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a table of one-cycle vectors followed by
// hand-written interrupt, priority and mid-redirect reset sequences.
module tb_trap_ctrl;

`ifdef COTM32_MTVEC_VECTORED_EN
  localparam logic [31:0] MTVEC_RD  = 32'h0000_2001;
  localparam logic [31:0] IRQ_TGT   = 32'h0000_202C;
`else
  localparam logic [31:0] MTVEC_RD  = 32'h0000_2000;
  localparam logic [31:0] IRQ_TGT   = 32'h0000_2000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] pc;
  logic        trap_req;
  logic [4:0]  trap_cause;
  logic [31:0] trap_tval;
  logic        mret;
  logic        irq_ext;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  trap_ctrl #(
    .RESET_MTVEC    (32'h0000_0000),
    .IRQ_SYNC_STAGES(2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_inst_valid (inst_valid),
    .i_pc         (pc),
    .i_trap_req   (trap_req),
    .i_trap_cause (trap_cause),
    .i_trap_tval  (trap_tval),
    .i_mret       (mret),
    .i_irq_ext    (irq_ext),
    .i_csr_addr   (csr_addr),
    .i_csr_we     (csr_we),
    .i_csr_wdata  (csr_wdata),
    .o_csr_rdata  (csr_rdata),
    .o_csr_hit    (csr_hit),
    .o_redirect   (redirect),
    .o_redirect_pc(redirect_pc),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        tr;
    logic [4:0]  cause;
    logic [31:0] tval;
    logic        mr;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_busy;
    logic [11:0] c_addr;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(logic v, logic [31:0] p, logic tr, logic [4:0] c,
                              logic [31:0] tv, logic mr, logic we, logic [11:0] wa,
                              logic [31:0] wd, logic er, logic [31:0] epc, logic eb,
                              logic [11:0] ca, logic [31:0] ed);
    vec_t r;
    r.v = v; r.pc = p; r.tr = tr; r.cause = c; r.tval = tv; r.mr = mr;
    r.we = we; r.waddr = wa; r.wdata = wd; r.e_redir = er; r.e_rpc = epc;
    r.e_busy = eb; r.c_addr = ca; r.e_rdata = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic tr,
                       input logic [4:0] c, input logic [31:0] tv, input logic mr,
                       input logic we, input logic [11:0] wa, input logic [31:0] wd);
    inst_valid = v; pc = p; trap_req = tr; trap_cause = c; trap_tval = tv;
    mret = mr; csr_we = we; csr_addr = wa; csr_wdata = wd;
  endtask

  task automatic nop(input logic [31:0] p);
    drive(1'b1, p, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    inst_valid = 1'b0; csr_we = 1'b0; trap_req = 1'b0; mret = 1'b0;
    csr_addr = a;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  task automatic chk_redir(input string name, input logic er, input logic [31:0] epc);
    chk({name, ".redirect"}, 32'(redirect), 32'(er));
    chk({name, ".busy"}, 32'(busy), 32'(er));
    if (er) chk({name, ".redirect_pc"}, redirect_pc, epc);
  endtask

  initial begin
    vecs[0]  = mk(1, 32'h80,  0, 5'd0,  32'h0,         0, 1, 12'h300, 32'h8,         0, 32'h0,    0, 12'h300, 32'h1808);
    vecs[1]  = mk(1, 32'h100, 1, 5'd2,  32'hDEAD_BEEF, 0, 0, 12'h000, 32'h0,         1, 32'h0,    1, 12'h341, 32'h100);
    vecs[2]  = mk(1, 32'h104, 1, 5'd3,  32'h1,         1, 1, 12'h340, 32'h7,         0, 32'h0,    0, 12'h340, 32'h0);
    vecs[3]  = mk(1, 32'h104, 0, 5'd0,  32'h0,         0, 0, 12'h000, 32'h0,         0, 32'h0,    0, 12'h342, 32'h2);
    vecs[4]  = mk(1, 32'h104, 0, 5'd0,  32'h0,         0, 0, 12'h000, 32'h0,         0, 32'h0,    0, 12'h343, 32'hDEAD_BEEF);
    vecs[5]  = mk(1, 32'h104, 0, 5'd0,  32'h0,         0, 0, 12'h000, 32'h0,         0, 32'h0,    0, 12'h300, 32'h1880);
    vecs[6]  = mk(1, 32'h104, 0, 5'd0,  32'h0,         1, 0, 12'h000, 32'h0,         1, 32'h100,  1, 12'h300, 32'h1888);
    vecs[7]  = mk(1, 32'h104, 0, 5'd0,  32'h0,         0, 0, 12'h000, 32'h0,         0, 32'h0,    0, 12'h341, 32'h100);
    vecs[8]  = mk(0, 32'h200, 1, 5'd5,  32'h99,        0, 0, 12'h000, 32'h0,         0, 32'h0,    0, 12'h341, 32'h100);
    vecs[9]  = mk(1, 32'h104, 0, 5'd0,  32'h0,         0, 1, 12'h341, 32'h303,       0, 32'h0,    0, 12'h341, 32'h300);
    vecs[10] = mk(1, 32'h104, 0, 5'd0,  32'h0,         1, 0, 12'h000, 32'h0,         1, 32'h300,  1, 12'h300, 32'h1888);
    vecs[11] = mk(1, 32'h104, 0, 5'd0,  32'h0,         0, 0, 12'h000, 32'h0,         0, 32'h0,    0, 12'h305, 32'h0);
    vecs[12] = mk(1, 32'h104, 0, 5'd0,  32'h0,         0, 1, 12'h305, 32'h2001,      0, 32'h0,    0, 12'h305, MTVEC_RD);
    vecs[13] = mk(1, 32'h104, 0, 5'd0,  32'h0,         0, 1, 12'h305, 32'h2003,      0, 32'h0,    0, 12'h305, MTVEC_RD);
    vecs[14] = mk(1, 32'h104, 0, 5'd0,  32'h0,         0, 1, 12'h304, 32'hFFFF_FFFF, 0, 32'h0,    0, 12'h304, 32'h800);
    vecs[15] = mk(1, 32'h104, 0, 5'd0,  32'h0,         0, 1, 12'h344, 32'hFFFF_FFFF, 0, 32'h0,    0, 12'h344, 32'h0);
    vecs[16] = mk(1, 32'h104, 0, 5'd0,  32'h0,         0, 1, 12'h342, 32'h1234,      0, 32'h0,    0, 12'h342, 32'h1234);
    vecs[17] = mk(1, 32'h404, 1, 5'd11, 32'h55,        0, 0, 12'h000, 32'h0,         1, 32'h2000, 1, 12'h342, 32'hB);
    vecs[18] = mk(1, 32'h104, 0, 5'd0,  32'h0,         0, 0, 12'h000, 32'h0,         0, 32'h0,    0, 12'h300, 32'h1880);
    vecs[19] = mk(1, 32'h104, 0, 5'd0,  32'h0,         0, 0, 12'h000, 32'h0,         0, 32'h0,    0, 12'h7C0, 32'h0);

    // Reset
    rst_n = 1'b0; irq_ext = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk_redir("reset", 1'b0, 32'h0);
    chk("reset.redirect_pc", redirect_pc, 32'h0);
    rd("reset.mstatus", 12'h300, 32'h1800);
    rd("reset.mtvec", 12'h305, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of one-cycle vectors
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].tr, vecs[i].cause, vecs[i].tval,
            vecs[i].mr, vecs[i].we, vecs[i].waddr, vecs[i].wdata);
      step();
      chk_redir($sformatf("v%0d", i), vecs[i].e_redir, vecs[i].e_rpc);
      rd($sformatf("v%0d.csr%h", i, vecs[i].c_addr), vecs[i].c_addr, vecs[i].e_rdata);
    end
    rd("hit.unknown", 12'h7C0, 32'h0);
    chk("hit.unknown.flag", 32'(csr_hit), 32'h0);

    // External interrupt through the synchroniser
    drive(1'b1, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 12'h300, 32'h8);
    step();
    chk_redir("irq.setmie", 1'b0, 32'h0);
    irq_ext = 1'b1;
    nop(32'h600); step(); chk_redir("irq.sync1", 1'b0, 32'h0);
    nop(32'h600); step(); chk_redir("irq.sync2", 1'b0, 32'h0);
    nop(32'h600); step(); chk_redir("irq.take", 1'b1, IRQ_TGT);
    rd("irq.mcause", 12'h342, 32'h8000_000B);
    rd("irq.mtval", 12'h343, 32'h0);
    rd("irq.mepc", 12'h344 - 12'h3, 32'h600);
    rd("irq.mip", 12'h344, 32'h800);
    rd("irq.mstatus", 12'h300, 32'h1880);
    nop(32'h604); step(); chk_redir("irq.done", 1'b0, 32'h0);

    // Exception beats pending interrupt and same-cycle CSR write
    drive(1'b1, 32'h604, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 12'h300, 32'h88);
    step();
    chk_redir("prio.setmie", 1'b0, 32'h0);
    rd("prio.mstatus", 12'h300, 32'h1888);
    drive(1'b1, 32'h500, 1'b1, 5'd4, 32'h77, 1'b0, 1'b1, 12'h340, 32'h5);
    step();
    chk_redir("prio.exc", 1'b1, 32'h2000);
    rd("prio.mcause", 12'h342, 32'h4);
    rd("prio.mscratch", 12'h340, 32'h0);
    rd("prio.mtval", 12'h343, 32'h77);
    rd("prio.mepc", 12'h341, 32'h500);
    nop(32'h504); step(); chk_redir("prio.hold1", 1'b0, 32'h0);
    nop(32'h504); step(); chk_redir("prio.hold2", 1'b0, 32'h0);
    rd("prio.mcause.keep", 12'h342, 32'h4);
    drive(1'b1, 32'h504, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 12'h000, 32'h0);
    step();
    chk_redir("prio.mret", 1'b1, 32'h500);
    rd("prio.mret.mstatus", 12'h300, 32'h1888);
    nop(32'h700); step(); chk_redir("prio.exit", 1'b0, 32'h0);
    nop(32'h700); step(); chk_redir("prio.irq", 1'b1, IRQ_TGT);
    rd("prio.irq.mcause", 12'h342, 32'h8000_000B);
    rd("prio.irq.mepc", 12'h341, 32'h700);

    // Reset while redirecting into the trap handler
    #3;
    rst_n = 1'b0;
    #1;
    chk_redir("rst.mid", 1'b0, 32'h0);
    rd("rst.mstatus", 12'h300, 32'h1800);
    rd("rst.mepc", 12'h341, 32'h0);
    rd("rst.mcause", 12'h342, 32'h0);
    rd("rst.mie", 12'h304, 32'h0);
    rd("rst.mip", 12'h344, 32'h0);
    rd("rst.mtvec", 12'h305, 32'h0);
    chk("rst.hit", 32'(csr_hit), 32'h1);
    irq_ext = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nop(32'h0); step(); chk_redir("rst.after", 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
